// File: rtl/dram_cmd_scheduler_if.sv
// Request/refresh handshake plus command, response and statistics bus of the
// DDR4 command scheduler. The scheduler takes the slave view.
interface dram_cmd_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [35:0] req_addr;
  logic        req_write;
  logic        refresh_req;
  logic        refresh_ack;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        resp_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] empty_count;

  modport master (
    output req_valid, req_addr, req_write, refresh_req,
    input  req_ready, refresh_ack, cmd_valid, cmd_type, cmd_bg, cmd_bank,
           cmd_row, cmd_col, resp_valid, hit_count, miss_count, empty_count
  );

  modport slave (
    input  req_valid, req_addr, req_write, refresh_req,
    output req_ready, refresh_ack, cmd_valid, cmd_type, cmd_bg, cmd_bank,
           cmd_row, cmd_col, resp_valid, hit_count, miss_count, empty_count
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Single-requester DDR4 command scheduler with an open-page policy.
// Tracks the open row of 16 banks, sequences PRE/ACT/RD/WR per request and
// PREA/REF per refresh, spacing commands with a single 10-bit down-counter.
module dram_cmd_scheduler #(
  parameter int T_RCD   = 24,
  parameter int T_RP    = 24,
  parameter int T_CL    = 24,
  parameter int T_CWL   = 20,
  parameter int T_BURST = 4,
  parameter int T_RFC   = 350
) (
  input logic                 clock,
  input logic                 reset,
  dram_cmd_scheduler_if.slave bus
);
  localparam logic [2:0] CMD_ACT  = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_PRE  = 3'd3;
  localparam logic [2:0] CMD_PREA = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;

  // Timer reload values: the next event fires T cycles after the load cycle.
  localparam logic [9:0] LOAD_RP  = 10'(T_RP - 1);
  localparam logic [9:0] LOAD_RCD = 10'(T_RCD - 1);
  localparam logic [9:0] LOAD_RD  = 10'(T_CL + T_BURST - 1);
  localparam logic [9:0] LOAD_WR  = 10'(T_CWL + T_BURST - 1);
  localparam logic [9:0] LOAD_RFC = 10'(T_RFC - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_DECODE     = 4'd1,
    S_ISSUE_PRE  = 4'd2,
    S_ISSUE_ACT  = 4'd3,
    S_ISSUE_COL  = 4'd4,
    S_ISSUE_PREA = 4'd5,
    S_ISSUE_REF  = 4'd6,
    S_WAIT_DATA  = 4'd7,
    S_WAIT_RFC   = 4'd8
  } state_t;

  state_t      state_r, state_s;
  logic [9:0]  timer_r;
  logic [29:0] addr_r;          // request address bits [35:6]
  logic        write_r;
  logic        refresh_mode_r;
  logic [15:0] valid_r;
  logic [14:0] row_r [16];
  logic [15:0] hit_r, miss_r, empty_r;

  logic [3:0]  idx_s;
  logic [14:0] row_s;
  logic [10:0] col_s;
  logic        timer_zero_s;
  logic        timer_load_s;
  logic [9:0]  timer_val_s;
  logic        accept_s, refresh_start_s;
  logic        hit_inc_s, miss_inc_s, empty_inc_s;
  logic        clr_entry_s, set_entry_s, clr_all_s;
  logic        req_ready_s, refresh_ack_s, resp_valid_s, cmd_valid_s;
  logic [2:0]  cmd_type_s;
  logic [1:0]  cmd_bg_s, cmd_bank_s;
  logic [14:0] cmd_row_s;
  logic [10:0] cmd_col_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx_s        = addr_r[29:26];
  assign row_s        = addr_r[25:11];
  assign col_s        = addr_r[10:0];
  assign timer_zero_s = (timer_r == 10'd0);

  // Next-state, command strobes and table/counter update requests.
  always_comb begin
    state_s         = state_r;
    timer_load_s    = 1'b0;
    timer_val_s     = 10'd0;
    accept_s        = 1'b0;
    refresh_start_s = 1'b0;
    hit_inc_s       = 1'b0;
    miss_inc_s      = 1'b0;
    empty_inc_s     = 1'b0;
    clr_entry_s     = 1'b0;
    set_entry_s     = 1'b0;
    clr_all_s       = 1'b0;
    req_ready_s     = 1'b0;
    refresh_ack_s   = 1'b0;
    resp_valid_s    = 1'b0;
    cmd_valid_s     = 1'b0;
    cmd_type_s      = 3'd0;
    cmd_bg_s        = 2'd0;
    cmd_bank_s      = 2'd0;
    cmd_row_s       = 15'd0;
    cmd_col_s       = 11'd0;
    case (state_r)
      S_IDLE: begin
        // A pending refresh blocks acceptance so the handshake never lies.
        req_ready_s = !bus.refresh_req;
        if (bus.refresh_req) begin
          refresh_start_s = 1'b1;
          state_s         = S_DECODE;
        end else if (bus.req_valid) begin
          accept_s = 1'b1;
          state_s  = S_DECODE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DECODE: begin
        if (refresh_mode_r) begin
          state_s = (valid_r != 16'd0) ? S_ISSUE_PREA : S_ISSUE_REF;
        end else if (!valid_r[idx_s]) begin
          empty_inc_s = 1'b1;
          state_s     = S_ISSUE_ACT;
        end else if (row_r[idx_s] == row_s) begin
          hit_inc_s = 1'b1;
          state_s   = S_ISSUE_COL;
        end else begin
          miss_inc_s = 1'b1;
          state_s    = S_ISSUE_PRE;
        end
      end
      S_ISSUE_PRE: begin
        if (timer_zero_s) begin
          cmd_valid_s  = 1'b1;
          cmd_type_s   = CMD_PRE;
          cmd_bg_s     = addr_r[29:28];
          cmd_bank_s   = addr_r[27:26];
          clr_entry_s  = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = LOAD_RP;
          state_s      = S_ISSUE_ACT;
        end else begin
          state_s = S_ISSUE_PRE;
        end
      end
      S_ISSUE_ACT: begin
        if (timer_zero_s) begin
          cmd_valid_s  = 1'b1;
          cmd_type_s   = CMD_ACT;
          cmd_bg_s     = addr_r[29:28];
          cmd_bank_s   = addr_r[27:26];
          cmd_row_s    = row_s;
          set_entry_s  = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = LOAD_RCD;
          state_s      = S_ISSUE_COL;
        end else begin
          state_s = S_ISSUE_ACT;
        end
      end
      S_ISSUE_COL: begin
        if (timer_zero_s) begin
          cmd_valid_s  = 1'b1;
          cmd_type_s   = write_r ? CMD_WR : CMD_RD;
          cmd_bg_s     = addr_r[29:28];
          cmd_bank_s   = addr_r[27:26];
          cmd_col_s    = col_s;
          timer_load_s = 1'b1;
          timer_val_s  = write_r ? LOAD_WR : LOAD_RD;
          state_s      = S_WAIT_DATA;
        end else begin
          state_s = S_ISSUE_COL;
        end
      end
      S_ISSUE_PREA: begin
        if (timer_zero_s) begin
          cmd_valid_s  = 1'b1;
          cmd_type_s   = CMD_PREA;
          clr_all_s    = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = LOAD_RP;
          state_s      = S_ISSUE_REF;
        end else begin
          state_s = S_ISSUE_PREA;
        end
      end
      S_ISSUE_REF: begin
        if (timer_zero_s) begin
          cmd_valid_s  = 1'b1;
          cmd_type_s   = CMD_REF;
          timer_load_s = 1'b1;
          timer_val_s  = LOAD_RFC;
          state_s      = S_WAIT_RFC;
        end else begin
          state_s = S_ISSUE_REF;
        end
      end
      S_WAIT_DATA: begin
        if (timer_zero_s) begin
          resp_valid_s = 1'b1;
          state_s      = S_IDLE;
        end else begin
          state_s = S_WAIT_DATA;
        end
      end
      S_WAIT_RFC: begin
        if (timer_zero_s) begin
          refresh_ack_s = 1'b1;
          state_s       = S_IDLE;
        end else begin
          state_s = S_WAIT_RFC;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register, inter-command timer and latched request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= S_IDLE;
      timer_r        <= 10'd0;
      addr_r         <= 30'd0;
      write_r        <= 1'b0;
      refresh_mode_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (timer_load_s) begin
        timer_r <= timer_val_s;
      end else if (!timer_zero_s) begin
        timer_r <= timer_r - 10'd1;
      end
      if (accept_s) begin
        addr_r         <= bus.req_addr[35:6];
        write_r        <= bus.req_write;
        refresh_mode_r <= 1'b0;
      end else if (refresh_start_s) begin
        refresh_mode_r <= 1'b1;
      end
    end
  end

  // Open-row table: PRE closes one bank, PREA closes all, ACT opens one.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        row_r[i] <= 15'd0;
      end
    end else if (clr_all_s) begin
      valid_r <= 16'd0;
    end else if (clr_entry_s) begin
      valid_r[idx_s] <= 1'b0;
    end else if (set_entry_s) begin
      valid_r[idx_s] <= 1'b1;
      row_r[idx_s]   <= row_s;
    end
  end

  // Saturating page-hit / page-miss / bank-closed statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_r   <= 16'd0;
      miss_r  <= 16'd0;
      empty_r <= 16'd0;
    end else begin
      if (hit_inc_s)   hit_r   <= sat_inc(hit_r);
      if (miss_inc_s)  miss_r  <= sat_inc(miss_r);
      if (empty_inc_s) empty_r <= sat_inc(empty_r);
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.refresh_ack = refresh_ack_s;
  assign bus.resp_valid  = resp_valid_s;
  assign bus.cmd_valid   = cmd_valid_s;
  assign bus.cmd_type    = cmd_type_s;
  assign bus.cmd_bg      = cmd_bg_s;
  assign bus.cmd_bank    = cmd_bank_s;
  assign bus.cmd_row     = cmd_row_s;
  assign bus.cmd_col     = cmd_col_s;
  assign bus.hit_count   = hit_r;
  assign bus.miss_count  = miss_r;
  assign bus.empty_count = empty_r;
endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Single-requester DDR4 command scheduler between the memory controller's request queue and the DRAM command model. It accepts one decoded memory operation at a time and tracks the open row of each of the 16 banks (4 bank groups × 4 banks) under an open-page policy. It issues the required PRE/ACT/RD/WR command sequence with parameterised inter-command delays, and services refresh requests with PREA/REF.

## Interface
Parameters:
- T_RCD, 24: ACT to RD/WR delay, in cycles (1..1023)
- T_RP, 24: PRE/PREA to ACT/REF delay, in cycles (1..1023)
- T_CL, 24: RD to first data, in cycles
- T_CWL, 20: WR to first data, in cycles
- T_BURST, 4: data burst length, in cycles
- T_RFC, 350: REF to next command, in cycles (1..1023)

Ports:
- clock, in, 1: sole clock; all logic on posedge
- reset, in, 1: synchronous, active-high
- req_valid, in, 1: request present
- req_ready, out, 1: scheduler can accept a request
- req_addr, in, 36: bg=[35:34], bank=[33:32], row=[31:17], col=[16:6]
- req_write, in, 1: 1=write, 0=read
- refresh_req, in, 1: level; refresh wanted
- refresh_ack, out, 1: one-cycle pulse when refresh completes
- cmd_valid, out, 1: one-cycle strobe; command fields valid
- cmd_type, out, 3: ACT=0, RD=1, WR=2, PRE=3, PREA=4, REF=5
- cmd_bg, out, 2: bank group of command
- cmd_bank, out, 2: bank of command
- cmd_row, out, 15: row (ACT only; otherwise 0)
- cmd_col, out, 11: column (RD/WR only; otherwise 0)
- resp_valid, out, 1: one-cycle pulse when the data burst of the current RD/WR ends
- hit_count, out, 16: saturating page-hit count
- miss_count, out, 16: saturating page-miss count
- empty_count, out, 16: saturating bank-closed count

## Operation
- Internal state: a 16-entry open table (valid bit + 15-bit row), indexed {bg,bank}. Holds the latched request. A 10-bit down-counter `timer`.
- FSM states: IDLE, DECODE, ISSUE_PRE, ISSUE_ACT, ISSUE_COL, ISSUE_PREA, ISSUE_REF, WAIT_DATA, WAIT_RFC.
- IDLE: req_ready=1.
  - refresh_req has priority. If refresh_req=1, do not accept a request; go to DECODE in refresh mode.
  - Otherwise, req_valid&&req_ready latches addr/write and goes to DECODE.
- DECODE, request mode: classify and count the request.
  - HIT (entry valid, row equal): go to ISSUE_COL; hit_count++.
  - EMPTY (entry invalid): go to ISSUE_ACT; empty_count++.
  - MISS (entry valid, row differs): go to ISSUE_PRE; miss_count++.
- DECODE, refresh mode: if any entry is valid, go to ISSUE_PREA; else go to ISSUE_REF.
- Each ISSUE_* state:
  - Waits until timer==0.
  - In that cycle, drives cmd_valid=1 with its fields and loads the timer.
  - Then advances to its next state.
- Command effects:
  - PRE: clears the entry; timer=T_RP-1; next state ISSUE_ACT.
  - ACT: sets the entry to the row; timer=T_RCD-1; next state ISSUE_COL.
  - RD/WR: timer=T_CL+T_BURST-1 (RD) or T_CWL+T_BURST-1 (WR); next state WAIT_DATA.
  - PREA: clears all entries; cmd_bg/cmd_bank=0; timer=T_RP-1; next state ISSUE_REF.
  - REF: timer=T_RFC-1; next state WAIT_RFC.
- WAIT_DATA: at timer==0, pulse resp_valid and go to IDLE. The open row stays open.
- WAIT_RFC: at timer==0, pulse refresh_ack and go to IDLE.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset, taking effect at the next edge and overriding any in-progress state:
  - FSM goes to IDLE, timer=0, all table entries invalid, counters=0.
  - req_ready=1, and all other outputs are 0.
  - A reset in the middle of a sequence abandons it with no resp_valid or refresh_ack.
- Cycle numbering: if the acceptance edge is cycle 0, DECODE occupies cycle 1 and the first command strobes in cycle 2.
- Spacing: consecutive commands of one sequence are exactly T cycles apart (command at c, next at c+T).
- resp_valid asserts in the cycle c_col+T_CL+T_BURST (read) or c_col+T_CWL+T_BURST (write).
  - req_ready returns to 1 in the following cycle.
- Back-to-back: throughput is at most one request per sequence. There is no command overlap between requests.
- Exclusivity: cmd_valid, resp_valid and refresh_ack are each single-cycle pulses and are never asserted together.
- refresh_req sampled outside IDLE is held by the requester; it is serviced at the next IDLE.

## Test plan
- Empty read: reset, then request bg=1 bank=2 row=0x100 col=0x10 read at cycle 0.
  - ACT(1,2,0x100) at cycle 2, RD at 26, resp_valid at 54, req_ready=1 at 55.
  - empty_count=1.
- Page hit: the same row in the same bank as a write.
  - WR at acceptance+2, resp_valid at WR+24.
  - hit_count=1; no ACT/PRE issued.
- Page miss: the same bank with row 0x200, read.
  - PRE at +2, ACT(0x200) at +26, RD at +50, resp_valid at +78.
  - miss_count=1.
- Refresh with open banks: two banks open, refresh_req asserted in IDLE.
  - PREA at +2, REF at +26, refresh_ack at +376.
  - A subsequent access to either bank counts as EMPTY.
- Simultaneous refresh_req and req_valid in IDLE: refresh completes first and req_ready=0 throughout.
  - The request is accepted in the cycle after refresh_ack.
- Reset mid-operation: assert reset during the miss sequence between PRE and ACT.
  - Next cycle: all outputs are at reset values and counters=0.
  - No resp_valid follows.
  - A re-issued request is classified EMPTY.
